// File: rtl/rob_commit_if.sv
// Issue / CDB / retire bus of the reorder buffer. The ROB is the slave;
// the core-side logic (issue, functional units, regbank) is the master.
interface rob_commit_if #(
   parameter int TAG_W  = 3,
   parameter int DATA_W = 16,
   parameter int REG_W  = 4
);
   logic              alloc_valid;
   logic [3:0]        alloc_func;
   logic [REG_W-1:0]  alloc_rd;
   logic              alloc_ready;
   logic [TAG_W-1:0]  alloc_tag;

   logic              cdb_valid;
   logic [TAG_W-1:0]  cdb_tag;
   logic [DATA_W-1:0] cdb_data;

   logic              commit_ready;
   logic              commit_valid;
   logic [TAG_W-1:0]  commit_tag;
   logic [3:0]        commit_func;
   logic [REG_W-1:0]  commit_rd;
   logic [DATA_W-1:0] commit_data;
   logic              commit_wr_reg;
   logic              commit_wr_mem;

   logic              flush;
   logic [TAG_W:0]    count;
   logic              empty;

   modport master (
      output alloc_valid, alloc_func, alloc_rd, cdb_valid, cdb_tag, cdb_data, commit_ready,
      input  alloc_ready, alloc_tag, commit_valid, commit_tag, commit_func, commit_rd,
             commit_data, commit_wr_reg, commit_wr_mem, flush, count, empty
   );

   modport slave (
      input  alloc_valid, alloc_func, alloc_rd, cdb_valid, cdb_tag, cdb_data, commit_ready,
      output alloc_ready, alloc_tag, commit_valid, commit_tag, commit_func, commit_rd,
             commit_data, commit_wr_reg, commit_wr_mem, flush, count, empty
   );
endinterface

// File: rtl/rob_commit.sv
// 8-entry reorder buffer with in-order retire: allocate at tail, CDB writeback
// by tag, retire from head, full squash when a mispredicted branch retires.
module rob_commit #(
   parameter int DEPTH  = 8,
   parameter int TAG_W  = 3,
   parameter int DATA_W = 16,
   parameter int REG_W  = 4
) (
   input logic        clk1,
   input logic        rst_n,
   rob_commit_if.slave rob
);

   typedef struct packed {
      logic              busy;
      logic              done;
      logic [3:0]        func;
      logic [REG_W-1:0]  rd;
      logic [DATA_W-1:0] value;
   } entry_t;

   entry_t            rob_q [DEPTH];
   logic [TAG_W-1:0]  head_q;
   logic [TAG_W-1:0]  tail_q;
   logic [TAG_W:0]    count_q;
   logic              flush_q;

   entry_t            head_e;
   logic              full;
   logic              commit_valid;
   logic              commit_fire;
   logic              mispredict;
   logic              alloc_fire;

   // DEPTH is a power of two, so the count MSB alone marks the full state.
   always_comb begin
      head_e       = rob_q[head_q];
      full         = count_q[TAG_W];
      commit_valid = head_e.busy && head_e.done;
      commit_fire  = commit_valid && rob.commit_ready;
      mispredict   = commit_fire && head_e.value[0] &&
                     (head_e.func == 4'd6 || head_e.func == 4'd7);
      alloc_fire   = rob.alloc_valid && !full && !mispredict;
   end

   assign rob.alloc_ready   = !full && !mispredict;
   assign rob.alloc_tag     = tail_q;
   assign rob.commit_valid  = commit_valid;
   assign rob.commit_tag    = head_q;
   assign rob.commit_func   = head_e.func;
   assign rob.commit_rd     = head_e.rd;
   assign rob.commit_data   = head_e.value;
   assign rob.commit_wr_reg = commit_valid && (head_e.func <= 4'd4);
   assign rob.commit_wr_mem = commit_valid && (head_e.func == 4'd5);
   assign rob.flush         = flush_q;
   assign rob.count         = count_q;
   assign rob.empty         = (count_q == '0);

   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: payload fields are reset too so the head outputs read 0 after reset;
         // the array is small enough that this costs little.
         for (int i = 0; i < DEPTH; i++) rob_q[i] <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         flush_q <= 1'b0;
      end else begin
         // NOTE: non-blocking throughout, so every read below sees pre-edge state.
         flush_q <= mispredict;
         if (mispredict) begin
            for (int i = 0; i < DEPTH; i++) begin
               rob_q[i].busy <= 1'b0;
               rob_q[i].done <= 1'b0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
         end else begin
            if (rob.cdb_valid && rob_q[rob.cdb_tag].busy) begin
               rob_q[rob.cdb_tag].done  <= 1'b1;
               rob_q[rob.cdb_tag].value <= rob.cdb_data;
            end
            // Alloc never targets the head while it is busy: tail == head only when empty or full.
            if (alloc_fire) begin
               rob_q[tail_q] <= '{busy: 1'b1, done: 1'b0, func: rob.alloc_func,
                                  rd: rob.alloc_rd, value: '0};
               tail_q <= tail_q + 1'b1;
            end
            if (commit_fire) begin
               rob_q[head_q].busy <= 1'b0;
               rob_q[head_q].done <= 1'b0;
               head_q <= head_q + 1'b1;
            end
            case ({alloc_fire, commit_fire})
               2'b10:   count_q <= count_q + 1'b1;
               2'b01:   count_q <= count_q - 1'b1;
               default: count_q <= count_q;
            endcase
         end
      end
   end

endmodule
